run_controller: RTL

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// run_controller -- run/step/halt sequencer for a simple processor core.
//
// Decides each cycle whether the PC and the datapath may advance (pc_en).
// It supports continuous execution, single-stepping, stop requests, a halt
// opcode, and an optional address breakpoint.
//
// Optional feature macro: RUN_CONTROLLER_BREAKPOINT_EN
//   When the macro is defined, the breakpoint compare, the skip-on-resume flag
//   and the sticky bp_hit flag are built.
//   When the macro is undefined, bp_addr and bp_valid are accepted but ignored,
//   and bp_hit is tied to 0.
//
// Parameters
//   PC_W    : program-counter width
//   OP_W    : opcode width
//   HALT_OP : opcode that stops continuous execution (default all ones)
//   CNT_W   : width of the executed-cycle counter
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   request continuous execution
//   stop        in   request a halt (highest priority)
//   step        in   request exactly one executed instruction
//   pc_addr     in   current PC value
//   opcode      in   opcode of the instruction at pc_addr
//   bp_addr     in   breakpoint address
//   bp_valid    in   breakpoint armed
//   pc_en       out  advance PC / allow datapath writes this cycle
//   state       out  IDLE=0, RUN=1, STEP=2, HALT=3
//   halted      out  high while in HALT (forced low during reset)
//   bp_hit      out  sticky: execution stopped on the breakpoint
//   cycle_count out  saturating count of cycles with pc_en high
module run_controller #(
  parameter int              PC_W    = 8,
  parameter int              OP_W    = 7,
  parameter logic [OP_W-1:0] HALT_OP = '1,
  parameter int              CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [PC_W-1:0]  pc_addr,
  input  logic [OP_W-1:0]  opcode,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             pc_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] count_reg;
  logic             bp_match;
  logic             halt_cond;
  logic             leave_halt;

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
  logic skip_bp_reg;
  logic bp_hit_reg;

  // skip_bp masks the breakpoint for the first executed cycle after a resume,
  // so the instruction sitting on the breakpoint can actually execute.
  assign bp_match = bp_valid && (pc_addr == bp_addr) && !skip_bp_reg;
`else
  logic unused_bp;

  assign bp_match  = 1'b0;
  assign unused_bp = &{1'b0, pc_addr, bp_addr, bp_valid};
`endif

  assign halt_cond  = stop || (opcode == HALT_OP) || bp_match;
  assign leave_halt = (state_reg == HALT) && (state_next != HALT);

  // Next-state logic. stop > step > start wherever they matter.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, HALT: begin
        if (stop)       state_next = state_reg;
        else if (step)  state_next = STEP;
        else if (start) state_next = RUN;
      end
      RUN: begin
        if (halt_cond) state_next = HALT;
      end
      STEP: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // The step is a debug override, so only stop can block it.
  // HALT_OP and the breakpoint are ignored in STEP.
  // Reset gates pc_en immediately, not one cycle later.
  always_comb begin
    pc_en = 1'b0;
    if (!reset) begin
      if (state_reg == RUN)  pc_en = !halt_cond;
      if (state_reg == STEP) pc_en = !stop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && ((state_next == RUN) || (state_next == STEP)))
        count_reg <= '0;
      else if (pc_en && (count_reg != {CNT_W{1'b1}}))
        count_reg <= count_reg + CNT_W'(1);
    end
  end

`ifdef RUN_CONTROLLER_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_bp_reg <= 1'b0;
      bp_hit_reg  <= 1'b0;
    end else begin
      if (leave_halt)
        skip_bp_reg <= 1'b1;
      else if ((state_reg == RUN) || (state_reg == STEP))
        skip_bp_reg <= 1'b0;

      // bp_hit is credited only when the breakpoint itself stopped the run.
      // It is not credited when a coincident stop request stopped it.
      if (leave_halt)
        bp_hit_reg <= 1'b0;
      else if ((state_reg == RUN) && bp_match && !stop)
        bp_hit_reg <= 1'b1;
    end
  end

  assign bp_hit = bp_hit_reg;
`else
  assign bp_hit = 1'b0;
`endif

  assign state       = state_reg;
  assign halted      = (state_reg == HALT) && !reset;
  assign cycle_count = count_reg;

endmodule
